// File: rtl/bsg_reg_pkg.sv
// Shared types for the BSG configuration register slave.
// Holds the slave FSM encoding and the default BSG register map offsets
// (control register first, then the two data registers).
package bsg_reg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    RRESP = 2'd2,
    TURN  = 2'd3
  } state_t;

  localparam int CTRL_OFS  = 0;
  localparam int DATA0_OFS = 1;
  localparam int DATA1_OFS = 2;

endpackage

// File: rtl/bsg_reg_slave.sv
// Register-file slave: address beat then data beat, registers exposed on a flat bus.
// Latency: write visible on REG_OUT the cycle after the data beat; read response the cycle after the address beat.
// Backpressure: READY_OUT is registered; it drops for one bubble cycle after every read or write.
module bsg_reg_slave
  import bsg_reg_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    NUM_REGS   = DATA1_OFS + 1,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 8'h10
) (
  input  logic                           G_CLK_TX,
  input  logic                           rst,
  input  logic                           VALID_IN,
  input  logic                           WRITE_IN,
  input  logic [DATA_WIDTH-1:0]          ADDR_IN,
  input  logic [DATA_WIDTH-1:0]          DATA_IN,
  output logic                           READY_OUT,
  output logic                           VALID_OUT,
  output logic [DATA_WIDTH-1:0]          DATA_OUT,
  output logic                           ERR_OUT,
  output logic [NUM_REGS*DATA_WIDTH-1:0] REG_OUT
);

  // Range arithmetic is one bit wider than the address so that
  // BASE_ADDR+NUM_REGS never wraps back into the low addresses.
  localparam int            AW = DATA_WIDTH + 1;
  localparam logic [AW-1:0] LO = {1'b0, BASE_ADDR};
  localparam logic [AW-1:0] HI = LO + AW'(NUM_REGS);

  // One-hot register select; all zeros means the address is unmapped.
  function automatic logic [NUM_REGS-1:0] decode(input logic [DATA_WIDTH-1:0] a);
    logic [AW-1:0]       aw;
    logic [NUM_REGS-1:0] hit;
    aw  = {1'b0, a};
    hit = '0;
    if ((aw >= LO) && (aw < HI)) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        hit[i] = ((aw - LO) == AW'(i));
      end
    end
    return hit;
  endfunction

  state_t                state_q;
  logic                  ready_q;
  logic                  valid_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic                  beat;
  logic [NUM_REGS-1:0]   rd_hit;
  logic [NUM_REGS-1:0]   wr_hit;
  logic [DATA_WIDTH-1:0] rd_data;

  // READY_OUT comes only from a flop, so VALID_IN never reaches it combinationally.
  assign beat = VALID_IN && ready_q;

  // Decode the live address (reads answer straight from the address beat)
  // and the latched address (writes complete on the later data beat).
  always_comb begin
    rd_hit  = decode(ADDR_IN);
    wr_hit  = decode(addr_q);
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_hit[i]) begin
        rd_data = rd_data | regs_q[i];
      end
    end
  end

  // Handshake FSM, register array and registered response outputs.
  always_ff @(posedge G_CLK_TX or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      // Response flags are single-cycle pulses unless re-armed below.
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (beat) begin
            addr_q  <= ADDR_IN;
            write_q <= WRITE_IN;
            if (WRITE_IN) begin
              state_q <= WDATA;
            end else begin
              // Read answers during the RRESP bubble; unmapped reads return zero.
              state_q <= RRESP;
              ready_q <= 1'b0;
              valid_q <= 1'b1;
              err_q   <= ~|rd_hit;
              data_q  <= rd_data;
            end
          end
        end
        WDATA: begin
          if (beat) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (wr_hit[i] && write_q) begin
                regs_q[i] <= DATA_IN;
              end
            end
            err_q   <= ~|wr_hit;
            state_q <= TURN;
            ready_q <= 1'b0;
          end
        end
        RRESP: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        TURN: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign READY_OUT = ready_q;
  assign VALID_OUT = valid_q;
  assign ERR_OUT   = err_q;
  assign DATA_OUT  = data_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign REG_OUT[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

endmodule

// File: tb/tb_bsg_reg_slave.sv
// Bench for bsg_reg_slave: two instances (default map and a 16-register map
// at 8'hF8) share one stimulus stream, each checked against its own array model.
module tb_bsg_reg_slave;
  import bsg_reg_pkg::*;

  localparam int B3  = 'h10;
  localparam int N3  = 3;
  localparam int B16 = 'hF8;
  localparam int N16 = 16;

  logic         G_CLK_TX;
  logic         rst;
  logic         VALID_IN;
  logic         WRITE_IN;
  logic [7:0]   ADDR_IN;
  logic [7:0]   DATA_IN;

  logic         rdy3, vld3, err3;
  logic [7:0]   dat3;
  logic [23:0]  reg3;
  logic         rdy16, vld16, err16;
  logic [7:0]   dat16;
  logic [127:0] reg16;

  bsg_reg_slave u_dut3 (
    .G_CLK_TX (G_CLK_TX),
    .rst      (rst),
    .VALID_IN (VALID_IN),
    .WRITE_IN (WRITE_IN),
    .ADDR_IN  (ADDR_IN),
    .DATA_IN  (DATA_IN),
    .READY_OUT(rdy3),
    .VALID_OUT(vld3),
    .DATA_OUT (dat3),
    .ERR_OUT  (err3),
    .REG_OUT  (reg3)
  );

  bsg_reg_slave #(
    .DATA_WIDTH(8),
    .NUM_REGS  (16),
    .BASE_ADDR (8'hF8)
  ) u_dut16 (
    .G_CLK_TX (G_CLK_TX),
    .rst      (rst),
    .VALID_IN (VALID_IN),
    .WRITE_IN (WRITE_IN),
    .ADDR_IN  (ADDR_IN),
    .DATA_IN  (DATA_IN),
    .READY_OUT(rdy16),
    .VALID_OUT(vld16),
    .DATA_OUT (dat16),
    .ERR_OUT  (err16),
    .REG_OUT  (reg16)
  );

  initial begin
    G_CLK_TX = 1'b0;
    forever #5 G_CLK_TX = ~G_CLK_TX;
  end

  int cyc = 0;
  always @(posedge G_CLK_TX) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: register contents, last read data, handshake spacing.
  logic [7:0] m3  [N3];
  logic [7:0] m16 [N16];
  logic [7:0] last_rd3, last_rd16;
  bit         spacing_on;
  int         prev_cyc;
  int         prev_min;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit in_rng(input int a, input int base, input int num);
    return (a >= base) && (a < base + num);
  endfunction

  function automatic logic [127:0] flat3();
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < N3; i++) r[i*8 +: 8] = m3[i];
    return r;
  endfunction

  function automatic logic [127:0] flat16();
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < N16; i++) r[i*8 +: 8] = m16[i];
    return r;
  endfunction

  function automatic logic [7:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return 8'(8'h0E + $urandom_range(0, 6));
      1:       return 8'(8'hF6 + $urandom_range(0, 9));
      2:       return 8'($urandom_range(0, 9));
      default: return 8'($urandom);
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where the slave is ready.
  task automatic wait_ready();
    int n;
    n = 0;
    while (rdy3 !== 1'b1 && n < 20) begin
      @(negedge G_CLK_TX);
      n++;
    end
    if (rdy3 !== 1'b1) chk("ready_timeout", 128'(rdy3), 128'(1));
    chk("rdy16", 128'(rdy16), 128'(1));
    // Idle cycle: no pulses pending, read data held.
    chk("idle_vld3", 128'(vld3), 128'(0));
    chk("idle_err3", 128'(err3), 128'(0));
    chk("hold_dat3", 128'(dat3), 128'(last_rd3));
    chk("idle_vld16", 128'(vld16), 128'(0));
    chk("idle_err16", 128'(err16), 128'(0));
    chk("hold_dat16", 128'(dat16), 128'(last_rd16));
  endtask

  task automatic addr_beat(output int beat_cyc);
    wait_ready();
    @(posedge G_CLK_TX);
    @(negedge G_CLK_TX);
    beat_cyc = cyc;
    if (spacing_on) chk("addr_spacing", 128'(beat_cyc - prev_cyc), 128'(prev_min));
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int gap);
    int bc;
    VALID_IN = 1'b1;
    WRITE_IN = 1'b1;
    ADDR_IN  = a;
    DATA_IN  = 8'($urandom);
    addr_beat(bc);
    chk("wdata_rdy3", 128'(rdy3), 128'(1));
    chk("wdata_rdy16", 128'(rdy16), 128'(1));
    chk("wdata_err3", 128'(err3), 128'(0));
    for (int k = 0; k < gap; k++) begin
      VALID_IN = 1'b0;
      WRITE_IN = 1'($urandom);
      ADDR_IN  = 8'($urandom);
      DATA_IN  = 8'($urandom);
      @(negedge G_CLK_TX);
      chk("wdata_wait_rdy", 128'(rdy3), 128'(1));
    end
    VALID_IN = 1'b1;
    DATA_IN  = d;
    ADDR_IN  = 8'($urandom);
    WRITE_IN = 1'($urandom);
    @(posedge G_CLK_TX);
    @(negedge G_CLK_TX);
    chk("data_spacing", 128'(cyc - bc), 128'(1 + gap));
    if (in_rng(int'(a), B3, N3)) m3[int'(a) - B3] = d;
    if (in_rng(int'(a), B16, N16)) m16[int'(a) - B16] = d;
    chk("turn_rdy3", 128'(rdy3), 128'(0));
    chk("turn_rdy16", 128'(rdy16), 128'(0));
    chk("wr_err3", 128'(err3), 128'(!in_rng(int'(a), B3, N3)));
    chk("wr_err16", 128'(err16), 128'(!in_rng(int'(a), B16, N16)));
    chk("wr_vld3", 128'(vld3), 128'(0));
    chk("wr_reg3", 128'(reg3), flat3());
    chk("wr_reg16", reg16, flat16());
    prev_cyc   = bc;
    prev_min   = 3 + gap;
    spacing_on = 1'b1;
  endtask

  task automatic do_read(input logic [7:0] a);
    int bc;
    logic [7:0] e3, e16;
    VALID_IN = 1'b1;
    WRITE_IN = 1'b0;
    ADDR_IN  = a;
    DATA_IN  = 8'($urandom);
    addr_beat(bc);
    e3  = 8'h00;
    e16 = 8'h00;
    if (in_rng(int'(a), B3, N3)) e3 = m3[int'(a) - B3];
    if (in_rng(int'(a), B16, N16)) e16 = m16[int'(a) - B16];
    chk("rd_vld3", 128'(vld3), 128'(1));
    chk("rd_dat3", 128'(dat3), 128'(e3));
    chk("rd_err3", 128'(err3), 128'(!in_rng(int'(a), B3, N3)));
    chk("rresp_rdy3", 128'(rdy3), 128'(0));
    chk("rd_vld16", 128'(vld16), 128'(1));
    chk("rd_dat16", 128'(dat16), 128'(e16));
    chk("rd_err16", 128'(err16), 128'(!in_rng(int'(a), B16, N16)));
    chk("rd_reg3", 128'(reg3), flat3());
    last_rd3   = e3;
    last_rd16  = e16;
    ADDR_IN    = 8'($urandom);
    WRITE_IN   = 1'($urandom);
    prev_cyc   = bc;
    prev_min   = 2;
    spacing_on = 1'b1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < N3; i++) m3[i] = 8'h00;
    for (int i = 0; i < N16; i++) m16[i] = 8'h00;
    last_rd3   = 8'h00;
    last_rd16  = 8'h00;
    spacing_on = 1'b0;
  endtask

  // Entered at a negedge; holds reset for n cycles, returns one cycle after release.
  task automatic do_reset(input int n);
    rst = 1'b0;
    #1;
    clear_model();
    for (int k = 0; k < n; k++) begin
      chk("rst_rdy3", 128'(rdy3), 128'(0));
      chk("rst_vld3", 128'(vld3), 128'(0));
      chk("rst_err3", 128'(err3), 128'(0));
      chk("rst_dat3", 128'(dat3), 128'(0));
      chk("rst_reg3", 128'(reg3), 128'(0));
      chk("rst_rdy16", 128'(rdy16), 128'(0));
      chk("rst_reg16", reg16, 128'(0));
      @(negedge G_CLK_TX);
    end
    rst = 1'b1;
    #1;
    chk("rel_rdy3_before_edge", 128'(rdy3), 128'(0));
    @(negedge G_CLK_TX);
    chk("rel_rdy3", 128'(rdy3), 128'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, c2;
    rst      = 1'b0;
    VALID_IN = 1'b0;
    WRITE_IN = 1'b0;
    ADDR_IN  = 8'h00;
    DATA_IN  = 8'h00;
    prev_cyc = 0;
    prev_min = 0;
    clear_model();
    @(negedge G_CLK_TX);
    do_reset(3);

    // Directed: first write, write/read-back, out-of-range write and read.
    do_write(8'h10, 8'hA5, 0);
    chk("reg0_a5", 128'(reg3[7:0]), 128'(8'hA5));
    do_write(8'h12, 8'h3C, 0);
    do_read(8'h12);
    chk("reg2_3c", 128'(reg3[23:16]), 128'(8'h3C));
    do_write(8'h13, 8'hFF, 0);
    do_read(8'h0F);
    do_read(8'h10);

    // Back-to-back writes with VALID_IN held high.
    @(negedge G_CLK_TX);
    do_reset(2);
    do_write(8'h10, 8'h01, 0);
    c0 = prev_cyc;
    do_write(8'h11, 8'h02, 0);
    c1 = prev_cyc;
    do_write(8'h12, 8'h03, 0);
    c2 = prev_cyc;
    chk("b2b_gap01", 128'(c1 - c0), 128'(3));
    chk("b2b_gap12", 128'(c2 - c1), 128'(3));
    chk("b2b_reg", 128'(reg3), 128'(24'h030201));
    chk("b2b_ctrl", 128'(reg3[CTRL_OFS*8 +: 8]), 128'(8'h01));
    chk("b2b_data0", 128'(reg3[DATA0_OFS*8 +: 8]), 128'(8'h02));
    chk("b2b_data1", 128'(reg3[DATA1_OFS*8 +: 8]), 128'(8'h03));

    // Reset while waiting for the data beat of a write to 8'h11.
    VALID_IN = 1'b1;
    WRITE_IN = 1'b1;
    ADDR_IN  = 8'h11;
    DATA_IN  = 8'h00;
    addr_beat(c0);
    DATA_IN = 8'h99;
    do_reset(2);
    chk("midrst_reg3", 128'(reg3), 128'(0));
    do_write(8'h11, 8'h5A, 0);
    do_read(8'h11);

    // Large map at the top of the address space.
    for (int i = 0; i < 8; i++) do_write(8'(8'hF8 + i), 8'(8'hC0 + i), 0);
    chk("top_reg16", reg16[63:0], 128'(64'hC7C6C5C4C3C2C1C0));
    do_read(8'hFF);
    do_read(8'hF7);
    for (int i = 0; i < 8; i++) do_write(8'(i), 8'(8'h20 + i), 0);
    do_read(8'h00);
    do_read(8'h07);
    do_read(8'h12);

    // Randomized transactions with occasional stalls.
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        VALID_IN   = 1'b0;
        spacing_on = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge G_CLK_TX);
      end
      if ($urandom_range(0, 1) == 1) begin
        do_write(pick_addr(), 8'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
      end else begin
        do_read(pick_addr());
      end
    end

    VALID_IN = 1'b0;
    @(negedge G_CLK_TX);
    @(negedge G_CLK_TX);
    chk("final_reg3", 128'(reg3), flat3());
    chk("final_reg16", reg16, flat16());

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
